// File: rtl/sb_request_scheduler_pkg.sv
// Shared types for the sideband request scheduler: FSM states, cmd_sel codes,
// pend bit positions and the round-robin successor helper.
package usb4_sb_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam logic [1:0] SEL_ERR = 2'd0;
  localparam logic [1:0] SEL_WR  = 2'd1;
  localparam logic [1:0] SEL_RD  = 2'd2;
  localparam logic [1:0] SEL_TV  = 2'd3;

  // pend bit index equals the cmd_sel code of the same source
  localparam int PEND_ERR = 0;
  localparam int PEND_WR  = 1;
  localparam int PEND_RD  = 2;
  localparam int PEND_TV  = 3;

  function automatic logic [1:0] rr_next(input logic [1:0] sel);
    case (sel)
      SEL_WR:  return SEL_RD;
      SEL_RD:  return SEL_TV;
      default: return SEL_WR;
    endcase
  endfunction

endpackage

// File: rtl/sb_request_scheduler_if.sv
// Command handshake between the scheduler (master) and the transaction engine (slave).
interface sb_request_scheduler_if;
  logic       cmd_valid;
  logic [1:0] cmd_sel;
  logic       cmd_ready;
  logic       cmd_done;

  modport master (output cmd_valid, cmd_sel, input cmd_ready, cmd_done);
  modport slave  (input cmd_valid, cmd_sel, output cmd_ready, cmd_done);
endinterface

// File: rtl/sb_request_scheduler_rr_arb.sv
// Combinational pick: error always wins, otherwise round-robin over
// write/read/t_valid starting at rr_ptr.
module sb_rr_arb
  import usb4_sb_sched_pkg::*;
(
  input  logic [3:0] pend,
  input  logic [1:0] rr_ptr,
  output logic [1:0] grant_sel,
  output logic [1:0] next_ptr
);

  logic [1:0] c0, c1, c2;

  assign c0 = rr_ptr;
  assign c1 = rr_next(c0);
  assign c2 = rr_next(c1);

  always_comb begin
    grant_sel = SEL_ERR;
    next_ptr  = rr_ptr;
    if (!pend[PEND_ERR]) begin
      if (pend[c0]) begin
        grant_sel = c0;
        next_ptr  = rr_next(c0);
      end else if (pend[c1]) begin
        grant_sel = c1;
        next_ptr  = rr_next(c1);
      end else if (pend[c2]) begin
        grant_sel = c2;
        next_ptr  = rr_next(c2);
      end
    end
  end

endmodule

// File: rtl/sb_request_scheduler.sv
// Latches sideband event pulses as pending requests and issues them one at a
// time to the shared engine. Define SB_SCHED_TIMEOUT_EN to build the WAIT_DONE timeout.
module sb_request_scheduler
  import usb4_sb_sched_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_read_pul,
  input  logic                   s_write_pul,
  input  logic                   trans_error_pul,
  input  logic                   t_valid_pul,
  sb_request_scheduler_if.master cmd,
  output logic [3:0]             pend,
  output logic                   busy,
  output logic                   overrun,
  output logic                   timeout
);

  state_t     state;
  logic [1:0] rr_ptr, grant_sel, next_ptr;
  logic [3:0] pul, clr;
  logic       expire;

  assign pul = {t_valid_pul, s_read_pul, s_write_pul, trans_error_pul};

  always_comb begin
    clr = '0;
    if (state == ISSUE && cmd.cmd_ready) clr[cmd.cmd_sel] = 1'b1;
  end

  sb_rr_arb u_arb (
    .pend      (pend),
    .rr_ptr    (rr_ptr),
    .grant_sel (grant_sel),
    .next_ptr  (next_ptr)
  );

  // A pulse on the clearing edge re-arms the flag without counting as overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend    <= '0;
      overrun <= 1'b0;
    end else begin
      pend    <= (pend & ~clr) | pul;
      overrun <= |(pul & pend & ~clr);
    end
  end

`ifdef SB_SCHED_TIMEOUT_EN
  logic [TO_W-1:0] cnt;

  assign expire = (cnt == TO_W'(TIMEOUT_CYC - 1)) && !cmd.cmd_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= (state == WAIT_DONE) && expire;
      cnt     <= (state == WAIT_DONE) ? cnt + 1'b1 : '0;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^{TIMEOUT_CYC, TO_W};
  assign expire     = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cmd.cmd_valid <= 1'b0;
      cmd.cmd_sel   <= SEL_ERR;
      busy          <= 1'b0;
      rr_ptr        <= SEL_WR;
    end else begin
      case (state)
        IDLE: if (|pend) begin
          cmd.cmd_sel   <= grant_sel;
          rr_ptr        <= next_ptr;
          cmd.cmd_valid <= 1'b1;
          busy          <= 1'b1;
          state         <= ISSUE;
        end
        ISSUE: if (cmd.cmd_ready) begin
          cmd.cmd_valid <= 1'b0;
          state         <= WAIT_DONE;
        end
        WAIT_DONE: if (cmd.cmd_done || expire) begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sb_request_scheduler.sv
// Bench for sb_request_scheduler: directed scenarios plus random traffic, all
// compared every cycle against a transaction-level model of the scheduler.
module tb_sb_request_scheduler;

  localparam int TO_CYC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_read_pul = 1'b0, s_write_pul = 1'b0;
  logic       trans_error_pul = 1'b0, t_valid_pul = 1'b0;
  logic [3:0] pend;
  logic       busy, overrun, timeout;

  sb_request_scheduler_if cif();

  sb_request_scheduler #(.TIMEOUT_CYC(TO_CYC), .TO_W(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .s_read_pul      (s_read_pul),
    .s_write_pul     (s_write_pul),
    .trans_error_pul (trans_error_pul),
    .t_valid_pul     (t_valid_pul),
    .cmd             (cif),
    .pend            (pend),
    .busy            (busy),
    .overrun         (overrun),
    .timeout         (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit chk_en = 1'b0;
  int gq[$];

  // Model: phase 0 idle, 1 offering a command, 2 engine working.
  bit [3:0] m_pend;
  int       m_phase, m_ptr, m_sel, m_wait;
  bit       m_ovr, m_to;

  task automatic m_reset();
    m_pend = '0; m_phase = 0; m_ptr = 1; m_sel = 0; m_wait = 0; m_ovr = 0; m_to = 0;
  endtask

  task automatic m_step();
    bit [3:0] p, clr;
    int nphase, s;
    bit to, found;
    p = {t_valid_pul, s_read_pul, s_write_pul, trans_error_pul};
    clr = '0;
    if (m_phase == 1 && cif.cmd_ready) clr[m_sel] = 1'b1;
    nphase = m_phase; to = 0; found = 0;
    if (m_phase == 0 && m_pend != 0) begin
      if (m_pend[0]) m_sel = 0;
      else for (int i = 0; i < 3; i++) begin
        s = ((m_ptr - 1 + i) % 3) + 1;
        if (!found && m_pend[s]) begin
          m_sel = s; m_ptr = (s % 3) + 1; found = 1;
        end
      end
      nphase = 1;
    end else if (m_phase == 1 && cif.cmd_ready) begin
      nphase = 2; m_wait = 0;
    end else if (m_phase == 2) begin
      m_wait++;
      if (cif.cmd_done) nphase = 0;
`ifdef SB_SCHED_TIMEOUT_EN
      else if (m_wait == TO_CYC) begin nphase = 0; to = 1; end
`endif
    end
    m_ovr   = |(p & m_pend & ~clr);
    m_pend  = (m_pend & ~clr) | p;
    m_to    = to;
    m_phase = nphase;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) m_reset();
      else m_step();
    end
  end

  always @(negedge clk) begin
    logic [9:0] e, a;
    if (chk_en && !reset) begin
      e = {m_phase == 1, 2'(m_sel), m_pend, m_phase != 0, m_ovr, m_to};
      a = {cif.cmd_valid, cif.cmd_sel, pend, busy, overrun, timeout};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL model_cmp t=%0t got=%b exp=%b (valid,sel,pend,busy,ovr,to)", $time, a, e);
      end
    end
  end

  always @(negedge clk)
    if (!reset && cif.cmd_valid && cif.cmd_ready) gq.push_back(int'(cif.cmd_sel));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((pend != 0 || busy) && k < budget) begin
      cif.cmd_ready = 1'b1;
      cif.cmd_done  = busy && !cif.cmd_valid;
      tick();
      k++;
    end
    cif.cmd_done  = 1'b0;
    cif.cmd_ready = 1'b0;
    chk("drain_budget", k < budget, 1);
  endtask

  task automatic chk_seq(input int n, input int e0, input int e1, input int e2, input int e3);
    int ex[4];
    ex = '{e0, e1, e2, e3};
    chk("grant_count", gq.size(), n);
    for (int i = 0; i < n; i++)
      chk("grant_order", (i < gq.size()) ? gq[i] : 99, ex[i]);
    gq.delete();
  endtask

  initial begin
    int k;
    bit found;
    cif.cmd_ready = 1'b0;
    cif.cmd_done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {cif.cmd_valid, cif.cmd_sel, pend, busy, overrun, timeout}, 0);
    reset = 1'b0;
    chk_en = 1'b1;

    // single read from idle
    s_read_pul = 1; tick(); s_read_pul = 0;
    chk("rd_pend", pend, 4'b0100);
    chk("rd_valid_early", cif.cmd_valid, 0);
    cif.cmd_ready = 1; tick();
    chk("rd_valid", cif.cmd_valid, 1);
    chk("rd_sel", cif.cmd_sel, 2);
    tick();
    chk("rd_pend_clr", pend, 0);
    chk("rd_busy_wait", busy, 1);
    tick();
    chk("rd_busy_hold", busy, 1);
    cif.cmd_done = 1; tick(); cif.cmd_done = 0;
    chk("rd_done_idle", busy, 0);
    gq.delete();

    // simultaneous error/write/read, then alternating write+read
    trans_error_pul = 1; s_write_pul = 1; s_read_pul = 1; tick();
    trans_error_pul = 0; s_write_pul = 0; s_read_pul = 0;
    drain(60);
    chk_seq(3, 0, 1, 2, 0);
    repeat (2) begin
      s_write_pul = 1; s_read_pul = 1; tick(); s_write_pul = 0; s_read_pul = 0;
      drain(60);
    end
    chk_seq(4, 1, 2, 1, 2);

    // read pulse on its own handshake edge
    s_read_pul = 1; tick(); s_read_pul = 0;
    cif.cmd_ready = 1; tick();
    s_read_pul = 1; tick(); s_read_pul = 0;
    chk("hs_pend_rd", pend[2], 1);
    chk("hs_no_ovr", overrun, 0);
    drain(60);
    chk_seq(2, 2, 2, 0, 0);

    // overrun while pending, cmd_ready held low
    cif.cmd_ready = 0;
    s_write_pul = 1; tick(); s_write_pul = 0; tick();
    chk("hold_valid", cif.cmd_valid, 1);
    chk("hold_sel", cif.cmd_sel, 1);
    s_read_pul = 1; tick(); s_read_pul = 0;
    chk("ovr_pend", pend, 4'b0110);
    chk("ovr_first", overrun, 0);
    s_read_pul = 1; tick(); s_read_pul = 0;
    chk("ovr_pulse", overrun, 1);
    tick();
    chk("ovr_one_cycle", overrun, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_stable", {cif.cmd_valid, cif.cmd_sel}, 3'b101);
    end

    // reset in WAIT_DONE with a read still pending
    cif.cmd_ready = 1; tick(); cif.cmd_ready = 0;
    chk("pre_rst_state", {cif.cmd_valid, pend, busy}, 6'b0_0100_1);
    #2 reset = 1;
    #1 chk("rst_async", {cif.cmd_valid, cif.cmd_sel, pend, busy, overrun, timeout}, 0);
    @(posedge clk); #1 reset = 0;
    tick();
    chk("rst_pend_lost", {pend, busy}, 0);
    gq.delete();

    // WAIT_DONE with no cmd_done
    s_write_pul = 1; s_read_pul = 1; tick(); s_write_pul = 0; s_read_pul = 0;
    cif.cmd_ready = 1; tick(); tick(); cif.cmd_ready = 0;
`ifdef SB_SCHED_TIMEOUT_EN
    k = 0; found = 0;
    for (int j = 1; j <= 10 && !found; j++) begin
      tick();
      if (timeout) begin found = 1; k = j; end
    end
    chk("to_latency", k, TO_CYC);
    chk("to_idle", busy, 0);
    tick();
    chk("to_next_issue", {cif.cmd_valid, cif.cmd_sel}, 3'b110);
`else
    k = 0; found = 0;
    repeat (20) begin
      tick();
      if (timeout || !busy) found = 1;
    end
    chk("no_to_exit", found, 0);
    chk("no_to_wait", {cif.cmd_valid, busy}, 2'b01);
`endif
    drain(60);

    // random traffic
    repeat (1500) begin
      trans_error_pul = ($urandom_range(0, 7) == 0);
      s_write_pul     = ($urandom_range(0, 4) == 0);
      s_read_pul      = ($urandom_range(0, 4) == 0);
      t_valid_pul     = ($urandom_range(0, 4) == 0);
      cif.cmd_ready   = 1'($urandom_range(0, 1));
      cif.cmd_done    = ($urandom_range(0, 5) == 0);
      tick();
    end
    {trans_error_pul, s_write_pul, s_read_pul, t_valid_pul} = '0;
    drain(300);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
